// File: rtl/seg7_monitor_if.sv
// Bus between a 7-segment display driver and the seg7_monitor reader.
// The driver side (master) owns the active-low segment lines; the monitor
// side (slave) returns the decoded digit, step events and step statistics.
interface seg7_monitor_if #(
    parameter int CNT_W = 8
);
    logic [6:0]       seg;        // {g,f,e,d,c,b,a}, 0 = segment lit
    logic [3:0]       digit;
    logic             digit_vld;
    logic             dir_up;
    logic             step_err;
    logic             illegal;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;

    modport master (
        output seg,
        input  digit, digit_vld, dir_up, step_err, illegal, up_cnt, dn_cnt
    );

    modport slave (
        input  seg,
        output digit, digit_vld, dir_up, step_err, illegal, up_cnt, dn_cnt
    );
endinterface

// File: rtl/seg7_monitor.sv
// seg7_monitor: reads active-low 7-segment lines back into a digit.
// Each pattern is debounced over STABLE_CYCLES samples, then evaluated once:
// blank is ignored, unknown/out-of-range patterns raise 'illegal', legal
// digits are classified as up/down steps (mod MOD) or flagged as step errors.
// Optional feature macro: SEG7_MON_STATS_EN enables the saturating up/down
// step counters; without it up_cnt/dn_cnt are tied to zero.
module seg7_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int MOD           = 6,
    parameter int CNT_W         = 8
) (
    input  logic          clk_i,
    input  logic          clr_i,
    seg7_monitor_if.slave bus
);
    localparam int              SC_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_EVAL   = SC_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]      MOD_L     = 4'(MOD);
    localparam logic [3:0]      MAX_DIGIT = 4'(MOD - 1);
    localparam logic [6:0]      BLANK     = 7'h7F;

    typedef enum logic {ST_EMPTY = 1'b0, ST_TRACK = 1'b1} state_t;

    // Active-low pattern to {hit, value}; hit=0 for anything not a digit.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    logic [6:0]      sample_q, last_q;
    logic [SC_W-1:0] stab_q, stab_d;
    state_t          state_q;
    logic [3:0]      digit_q;
    logic            vld_q, dir_q, err_q, ill_q;

    logic [4:0] dec_s;
    logic [3:0] nxt_up_s, nxt_dn_s;
    logic       eval_s, legal_s, new_pat_s, accept_s, bad_s;
    logic       is_up_s, is_dn_s, is_err_s;

    // Evaluation of the debounced pattern and step classification.
    always_comb begin
        dec_s     = decode(sample_q);
        // stab_q == STABLE_CYCLES-1 means STABLE_CYCLES identical samples so far;
        // the count saturates above this value, so an episode is seen only once.
        eval_s    = (stab_q == SC_EVAL);
        legal_s   = dec_s[4] && (dec_s[3:0] < MOD_L);
        new_pat_s = eval_s && (sample_q != last_q) && (sample_q != BLANK);
        accept_s  = new_pat_s && legal_s;
        bad_s     = new_pat_s && !legal_s;
        nxt_up_s  = (digit_q == MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
        nxt_dn_s  = (digit_q == 4'd0) ? MAX_DIGIT : digit_q - 4'd1;
        // Up is tested first so MOD=2 (where up and down coincide) counts as up.
        is_up_s   = accept_s && (state_q == ST_TRACK) && (dec_s[3:0] == nxt_up_s);
        is_dn_s   = accept_s && (state_q == ST_TRACK) && !is_up_s
                    && (dec_s[3:0] == nxt_dn_s);
        is_err_s  = accept_s && (state_q == ST_TRACK) && !is_up_s && !is_dn_s;
    end

    // Next value of the stability count: saturating run of identical samples.
    always_comb begin
        stab_d = stab_q;
        if (bus.seg == sample_q) begin
            if (stab_q == SC_MAX) begin
                stab_d = SC_MAX;
            end else begin
                stab_d = stab_q + SC_W'(1);
            end
        end else begin
            stab_d = {SC_W{1'b0}};
        end
    end

    // Sampler, tracking FSM and registered result outputs.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sample_q <= BLANK;
            stab_q   <= {SC_W{1'b0}};
            last_q   <= BLANK;
            state_q  <= ST_EMPTY;
            digit_q  <= 4'd0;
            vld_q    <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            sample_q <= bus.seg;
            stab_q   <= stab_d;
            vld_q    <= accept_s;
            err_q    <= is_err_s;
            ill_q    <= bad_s;
            if (accept_s || bad_s) begin
                last_q <= sample_q;
            end
            if (accept_s) begin
                digit_q <= dec_s[3:0];
                state_q <= ST_TRACK;
            end
            if (is_up_s) begin
                dir_q <= 1'b1;
            end else if (is_dn_s) begin
                dir_q <= 1'b0;
            end
        end
    end

    assign bus.digit     = digit_q;
    assign bus.digit_vld = vld_q;
    assign bus.dir_up    = dir_q;
    assign bus.step_err  = err_q;
    assign bus.illegal   = ill_q;

`ifdef SEG7_MON_STATS_EN
    logic [CNT_W-1:0] up_cnt_q, dn_cnt_q;

    // Saturating up/down step counters.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            up_cnt_q <= {CNT_W{1'b0}};
            dn_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (is_up_s && (up_cnt_q != {CNT_W{1'b1}})) begin
                up_cnt_q <= up_cnt_q + CNT_W'(1);
            end
            if (is_dn_s && (dn_cnt_q != {CNT_W{1'b1}})) begin
                dn_cnt_q <= dn_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.up_cnt = up_cnt_q;
    assign bus.dn_cnt = dn_cnt_q;
`else
    assign bus.up_cnt = {CNT_W{1'b0}};
    assign bus.dn_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_seg7_monitor.sv
// Self-checking bench for seg7_monitor. A behavioural model tracks the run
// length of identical samples and applies the decode/step rules directly;
// every cycle the full output bundle is compared with the model.
module tb_seg7_monitor;
    localparam int S     = 4;
    localparam int MOD   = 6;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SEG7_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int OW = 8 + 2 * CNT_W;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    seg7_monitor_if #(.CNT_W(CNT_W)) bus ();
    seg7_monitor #(.STABLE_CYCLES(S), .MOD(MOD), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .clr_i(clr), .bus(bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    // model state
    logic [6:0] pats [0:9];
    logic [6:0] m_cur, m_last;
    int         m_run, m_prev, e_digit, e_up, e_dn;
    bit         m_has, e_vld, e_dir, e_err, e_ill;
    logic [OW-1:0] exp_v;
    wire  [OW-1:0] obs_v = {bus.digit, bus.digit_vld, bus.dir_up, bus.step_err,
                            bus.illegal, bus.up_cnt, bus.dn_cnt};

    function automatic int dec_val(input logic [6:0] p);
        for (int i = 0; i < MOD; i++) if (pats[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = 7'h7F; m_run = 1; m_last = 7'h7F; m_has = 0; m_prev = 0;
        e_digit = 0; e_up = 0; e_dn = 0; e_vld = 0; e_dir = 0; e_err = 0; e_ill = 0;
    endtask

    task automatic model_eval(input logic [6:0] p);
        int n;
        if (p != m_last && p != 7'h7F) begin
            n = dec_val(p);
            m_last = p;
            if (n < 0) e_ill = 1;
            else begin
                e_vld = 1; e_digit = n;
                if (m_has) begin
                    if (n == (m_prev + 1) % MOD) begin
                        e_dir = 1; if (e_up < MAXC) e_up++;
                    end else if (n == (m_prev + MOD - 1) % MOD) begin
                        e_dir = 0; if (e_dn < MAXC) e_dn++;
                    end else e_err = 1;
                end
                m_has = 1; m_prev = n;
            end
        end
    endtask

    // drive one clock cycle and advance the model to the post-edge state
    task automatic cyc(input logic [6:0] v, input bit c);
        @(negedge clk);
        bus.seg = v; clr = c;
        @(posedge clk);
        e_vld = 0; e_err = 0; e_ill = 0;
        if (c) model_reset();
        else begin
            if (m_run == S) model_eval(m_cur);
            if (v == m_cur) m_run++;
            else begin m_cur = v; m_run = 1; end
        end
        exp_v = {4'(e_digit), e_vld, e_dir, e_err, e_ill,
                 CNT_W'(STATS ? e_up : 0), CNT_W'(STATS ? e_dn : 0)};
        #1;
    endtask

    task automatic test_reset();
        cyc(7'h7F, 1'b1);
        cyc(7'h40, 1'b1);
        total++;
        if (obs_v !== {OW{1'b0}}) $display("FAIL reset: got %h want %h", obs_v, {OW{1'b0}});
        else pass_cnt++;
    endtask

    task automatic test_first_digit();
        int pulses = 0;
        for (int i = 0; i < S + 3; i++) begin
            cyc(7'h40, 1'b0);
            pulses += bus.digit_vld;
            total++;
            if (obs_v !== exp_v) $display("FAIL first_digit cyc %0d: got %h want %h", i, obs_v, exp_v);
            else pass_cnt++;
            if (i == S) begin
                total++;
                if (bus.digit_vld !== 1'b1) $display("FAIL first_digit_latency: got %b want 1", bus.digit_vld);
                else pass_cnt++;
            end
        end
        total++;
        if (pulses != 1) $display("FAIL first_digit_pulses: got %0d want 1", pulses);
        else pass_cnt++;
    endtask

    task automatic test_up_sequence();
        int seq [7] = '{0, 1, 2, 3, 4, 5, 0};
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 7; k++)
            for (int j = 0; j < 6; j++) begin
                cyc(pats[seq[k]], 1'b0);
                total++;
                if (obs_v !== exp_v) $display("FAIL up_seq step %0d: got %h want %h", k, obs_v, exp_v);
                else pass_cnt++;
            end
        total++;
        if (bus.up_cnt !== CNT_W'(STATS ? 6 : 0) || bus.dir_up !== 1'b1)
            $display("FAIL up_seq_final: got up=%0d dir=%b want up=%0d dir=1",
                     bus.up_cnt, bus.dir_up, STATS ? 6 : 0);
        else pass_cnt++;
    endtask

    task automatic test_wrap_down();
        logic [6:0] seq [3] = '{7'h40, 7'h12, 7'h19};
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 6; j++) begin
                cyc(seq[k], 1'b0);
                total++;
                if (obs_v !== exp_v) $display("FAIL wrap_down step %0d: got %h want %h", k, obs_v, exp_v);
                else pass_cnt++;
            end
        total++;
        if (bus.dn_cnt !== CNT_W'(STATS ? 2 : 0) || bus.dir_up !== 1'b0 || bus.digit !== 4'd4)
            $display("FAIL wrap_down_final: got dn=%0d dir=%b digit=%0d want dn=%0d dir=0 digit=4",
                     bus.dn_cnt, bus.dir_up, bus.digit, STATS ? 2 : 0);
        else pass_cnt++;
    endtask

    task automatic test_err_illegal();
        logic [6:0] seq [5] = '{7'h79, 7'h30, 7'h02, 7'h7F, 7'h55};
        int errs = 0, ills = 0;
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 7; j++) begin
                cyc(seq[k], 1'b0);
                errs += bus.step_err; ills += bus.illegal;
                total++;
                if (obs_v !== exp_v) $display("FAIL err_illegal step %0d: got %h want %h", k, obs_v, exp_v);
                else pass_cnt++;
            end
        total++;
        if (errs != 1 || ills != 2 || bus.digit !== 4'd3)
            $display("FAIL err_illegal_counts: got err=%0d ill=%0d digit=%0d want 1 2 3", errs, ills, bus.digit);
        else pass_cnt++;
    endtask

    task automatic test_glitch_blank();
        // digit 2, glitch to 3 (2 cycles), back to 2, then 3 stable; then blank and 3 again
        logic [6:0] seq [7] = '{7'h24, 7'h30, 7'h24, 7'h30, 7'h7F, 7'h30, 7'h19};
        int     hold [7] = '{6, 2, 5, 6, 6, 6, 6};
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 7; k++)
            for (int j = 0; j < hold[k]; j++) begin
                cyc(seq[k], 1'b0);
                total++;
                if (obs_v !== exp_v) $display("FAIL glitch_blank step %0d: got %h want %h", k, obs_v, exp_v);
                else pass_cnt++;
            end
    endtask

    task automatic test_clr_accept();
        cyc(7'h7F, 1'b1);
        for (int j = 0; j < 6; j++) cyc(7'h40, 1'b0);
        for (int j = 0; j < S; j++) cyc(7'h79, 1'b0);
        cyc(7'h79, 1'b1);   // clr on the acceptance edge
        total++;
        if (obs_v !== {OW{1'b0}}) $display("FAIL clr_accept: got %h want %h", obs_v, {OW{1'b0}});
        else pass_cnt++;
        for (int j = 0; j < 6; j++) begin
            cyc(7'h24, 1'b0);   // first digit again: no step classification
            total++;
            if (obs_v !== exp_v) $display("FAIL clr_accept_after cyc %0d: got %h want %h", j, obs_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [6:0] v;
        int r, hold;
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      v = pats[(m_prev + 1) % MOD];
            else if (r < 50) v = pats[(m_prev + MOD - 1) % MOD];
            else if (r < 70) v = pats[$urandom_range(0, 9)];
            else if (r < 82) v = 7'h7F;
            else             v = 7'($urandom_range(0, 127));
            hold = $urandom_range(1, 7);
            for (int j = 0; j < hold; j++) begin
                cyc(v, 1'b0);
                total++;
                if (obs_v !== exp_v) $display("FAIL random seg %0d pat %h: got %h want %h", k, v, obs_v, exp_v);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturation();
        cyc(7'h7F, 1'b1);
        for (int k = 0; k < 265; k++)
            for (int j = 0; j < S + 1; j++) begin
                cyc(pats[k % MOD], 1'b0);
                total++;
                if (obs_v !== exp_v) $display("FAIL saturation step %0d: got %h want %h", k, obs_v, exp_v);
                else pass_cnt++;
            end
        total++;
        if (bus.up_cnt !== CNT_W'(STATS ? MAXC : 0))
            $display("FAIL saturation_final: got %0d want %0d", bus.up_cnt, STATS ? MAXC : 0);
        else pass_cnt++;
    endtask

    initial begin
        pats[0] = 7'h40; pats[1] = 7'h79; pats[2] = 7'h24; pats[3] = 7'h30; pats[4] = 7'h19;
        pats[5] = 7'h12; pats[6] = 7'h02; pats[7] = 7'h78; pats[8] = 7'h00; pats[9] = 7'h10;
        bus.seg = 7'h7F;
        model_reset();
        test_reset();
        test_first_digit();
        test_up_sequence();
        test_wrap_down();
        test_err_illegal();
        test_glitch_blank();
        test_clr_accept();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
